// File: rtl/timer_bank.sv
// timer_bank: N_CH independent down-counting timers behind one word-addressed
// slave port, with a shared write-1-to-clear pending register and masked IRQ.
module timer_bank #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      Addr,
  input  logic            WE,
  input  logic [31:0]     Din,
  output logic [31:0]     Dout,
  output logic            IRQ,
  output logic [N_CH-1:0] irq_vec
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CNT,
    INT
  } state_e;

  localparam logic [5:0] PEND_ADDR = 6'd60;

  logic [3:0]       ctrl_a   [N_CH];
  logic [CNT_W-1:0] preset_a [N_CH];
  logic [CNT_W-1:0] count_a  [N_CH];
  logic [N_CH-1:0]  hw_set;
  logic [N_CH-1:0]  im;
  logic [N_CH-1:0]  pend_q;
  logic [N_CH-1:0]  pend_d;
  logic [N_CH-1:0]  w1c;
  logic [31:0]      rdata;
  logic             unused_din;

  // Upper Din bits are don't-care for narrow fields.
  assign unused_din = ^Din;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_e           state_q;
    state_e           state_d;
    logic [3:0]       ctrl_q;
    logic [3:0]       ctrl_d;
    logic [CNT_W-1:0] preset_q;
    logic [CNT_W-1:0] preset_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             set;
    logic             sel;
    logic             ctrl_wr;
    logic             preset_wr;
    logic             en;
    logic             reload;

    assign sel       = WE && (Addr[5:2] == 4'(c));
    assign ctrl_wr   = sel && (Addr[1:0] == 2'd0);
    assign preset_wr = sel && (Addr[1:0] == 2'd1);
    assign en        = ctrl_q[0];
    assign reload    = (ctrl_q[2:1] == 2'b01);

    always_comb begin
      state_d  = state_q;
      ctrl_d   = ctrl_q;
      preset_d = preset_q;
      count_d  = count_q;
      set      = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (en) state_d = LOAD;
        end
        LOAD: begin
          count_d = preset_q;
          state_d = CNT;
        end
        CNT: begin
          if (!en) begin
            state_d = IDLE;
          end else if (count_q == '0) begin
            state_d = INT;
            set     = 1'b1;
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end
        INT: begin
          if (reload) begin
            state_d = en ? LOAD : IDLE;
          end else begin
            ctrl_d[0] = 1'b0;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      // A bus write lands after the FSM so software wins over the EN clear.
      if (ctrl_wr)   ctrl_d   = Din[3:0];
      if (preset_wr) preset_d = Din[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        state_q  <= IDLE;
        ctrl_q   <= '0;
        preset_q <= '0;
        count_q  <= '0;
      end else begin
        state_q  <= state_d;
        ctrl_q   <= ctrl_d;
        preset_q <= preset_d;
        count_q  <= count_d;
      end
    end

    assign ctrl_a[c]   = ctrl_q;
    assign preset_a[c] = preset_q;
    assign count_a[c]  = count_q;
    assign hw_set[c]   = set;
    assign im[c]       = ctrl_q[3];
  end

  assign w1c = (WE && (Addr == PEND_ADDR)) ? Din[N_CH-1:0] : '0;

  // Hardware set is OR-ed in last so it beats a same-cycle clear.
  assign pend_d = (pend_q & ~w1c) | hw_set;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (Addr == PEND_ADDR) begin
      rdata[N_CH-1:0] = pend_q;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (Addr[5:2] == 4'(c)) begin
          case (Addr[1:0])
            2'd0:    rdata[3:0]       = ctrl_a[c];
            2'd1:    rdata[CNT_W-1:0] = preset_a[c];
            2'd2:    rdata[CNT_W-1:0] = count_a[c];
            default: rdata            = '0;
          endcase
        end
      end
    end
  end

  assign Dout    = rdata;
  assign irq_vec = pend_q & im;
  assign IRQ     = |irq_vec;

endmodule

// File: doc/timer_bank.md
# timer_bank

Parametrised multi-channel timer/counter peripheral that sits behind the system bridge as a single memory-mapped slave. It provides N_CH independent down-counting timers, each with one-shot or auto-reload mode, one shared W1C interrupt-pending register, and per-channel interrupt enables. A single aggregated IRQ line goes to the CPU, and a per-channel IRQ vector is exposed for debug.

## Interface
- N_CH, 4, number of timer channels; legal range 1..8
- CNT_W, 32, width of PRESET/COUNT; legal range 1..32; values zero-extended on read, upper Din bits ignored on write
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset (reset==0 at a rising edge resets the block)
- Addr  input  6  word address within block (byte address bits [7:2])
- WE  input  1  write enable; full 32-bit word write at the rising edge
- Din  input  32  write data
- Dout  output  32  read data; combinational from Addr
- IRQ  output  1  |(IRQ_PEND & IM); combinational from registers
- irq_vec  output  N_CH  per-channel IRQ_PEND[c] & IM[c]

## Operation
- Register map per channel c (word 4c+k): k=0 CTRL (RW), k=1 PRESET (RW), k=2 COUNT (RO, writes ignored), k=3 reserved (reads 0).
- Word 60: IRQ_PEND, bits [N_CH-1:0]; read returns pending bits; write-1-to-clear.
- Unmapped words (including channel words for c ≥ N_CH): read 0, writes ignored.
- CTRL bits: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as one-shot), [3] IM. Bits [31:4] read 0.
- Per-channel FSM, states IDLE, LOAD, CNT, INT:
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT: if !EN, go to IDLE and hold COUNT. Else if COUNT==0, go to INT and set IRQ_PEND[c]. Else COUNT <= COUNT-1.
  - INT: one-shot clears EN and goes to IDLE. Auto-reload goes to LOAD; if EN was cleared by software, go to IDLE.
- PRESET writes during counting take effect only at the next LOAD.
- Writing CTRL with EN=1 while in CNT does not restart the count.
- Simultaneous events:
  - Hardware set and software W1C of the same IRQ_PEND bit in the same cycle: the set wins (bit stays 1).
  - Software CTRL write in the same cycle as the hardware EN clear in INT: the software value wins.
- Channels are fully independent. Any number of channels may set pending bits in the same cycle.

## Timing
- Reset values: CTRL, PRESET, COUNT, IRQ_PEND all 0; all FSMs in IDLE. Consequently IRQ=0, irq_vec=0, and Dout=0 for every Addr.
- Reset overrides any in-progress count and any concurrent write.
- Edge-numbering convention: E0 is the edge that writes CTRL.EN=1 with state IDLE and PRESET=P. Then:
  - E1: IDLE→LOAD
  - E2: COUNT=P, state CNT
  - E3..E(2+P): decrements
  - E(3+P): state INT, IRQ_PEND set; IRQ high after this edge
  - E(4+P): one-shot → IDLE with EN=0; auto-reload → LOAD
- Auto-reload period: P+3 cycles between successive pending-set edges.
- P=0: pending is set at E3.
- Register writes become visible on Dout in the cycle after the write edge.
- Clearing EN in CNT: the FSM leaves CNT on the edge after the write edge; COUNT holds its last value.

## Test plan
- Reset: hold reset=0 for 2 cycles mid-count, with CTRL=0x9 and P=100 → all reads 0, IRQ=0; the FSM does not restart after reset=1.
- One-shot: P=5, CTRL=0x9 on ch0 → IRQ_PEND[0] and IRQ rise exactly at E8; CTRL reads 0x8 after E9; COUNT reads 0; write 0x1 to word 60 → IRQ=0 next cycle.
- Auto-reload: ch2, P=3, CTRL=0xB → pending set at E6, E12, E18; a W1C issued in the same cycle as the E12 set leaves the bit at 1.
- Mask and multi-channel: ch0 P=2 with IM=0, ch1 P=2 with IM=1, enabled the same cycle → both pending bits set at E5; irq_vec=0b0010; IRQ=1.
- Abort and preset change: ch1 P=10; write EN=0 at E6 → state IDLE after E7; COUNT reads 6. Write PRESET=2, then EN=1 → new count starts from 2.
- Address decode with N_CH=2: read word 8 and word 59 → 0; write word 10 → no effect; write COUNT → ignored.
